// File: rtl/coordinate_centroid_seq_if.sv
// Pixel-stream input and centroid-result bundle for coordinate_centroid_seq.
// Defining COORD_BBOX_EN adds the bounding-box result fields.
interface coordinate_centroid_seq_if #(
    parameter int COOR_W = 10,
    parameter int CNT_W  = 19
);
    logic              vsync_i;
    logic              hsync_i;
    logic              data_en_i;
    logic              data_i;
    logic [COOR_W-1:0] x_coor;
    logic [COOR_W-1:0] y_coor;
    logic [CNT_W-1:0]  pix_cnt;
    logic              coor_valid_flag;
    logic              frame_done;
    logic              busy;
    logic [1:0]        o_dbg_state;
`ifdef COORD_BBOX_EN
    logic [COOR_W-1:0] x_min;
    logic [COOR_W-1:0] x_max;
    logic [COOR_W-1:0] y_min;
    logic [COOR_W-1:0] y_max;
`endif

    // No back-pressure: one pixel per clock is consumed while data_en_i=1. Result fields
    // change only on the cycle frame_done is high and hold until the next pulse; busy
    // marks the divider running.
`ifdef COORD_BBOX_EN
    modport master (
        output vsync_i, hsync_i, data_en_i, data_i,
        input  x_coor, y_coor, pix_cnt, coor_valid_flag, frame_done, busy, o_dbg_state,
        input  x_min, x_max, y_min, y_max
    );
    modport slave (
        input  vsync_i, hsync_i, data_en_i, data_i,
        output x_coor, y_coor, pix_cnt, coor_valid_flag, frame_done, busy, o_dbg_state,
        output x_min, x_max, y_min, y_max
    );
`else
    modport master (
        output vsync_i, hsync_i, data_en_i, data_i,
        input  x_coor, y_coor, pix_cnt, coor_valid_flag, frame_done, busy, o_dbg_state
    );
    modport slave (
        input  vsync_i, hsync_i, data_en_i, data_i,
        output x_coor, y_coor, pix_cnt, coor_valid_flag, frame_done, busy, o_dbg_state
    );
`endif
endinterface

// File: rtl/coordinate_centroid_seq.sv
// Per-frame target centroid using a sequential restoring divider.
// Optional macro COORD_BBOX_EN adds per-frame bounding-box outputs.
module coordinate_centroid_seq #(
    parameter int H_ACT   = 800,
    parameter int V_ACT   = 480,
    parameter int COOR_W  = 10,
    parameter int CNT_W   = 19,
    parameter int SUM_W   = 29,
    parameter int MIN_PIX = 1500
) (
    input logic clk,
    input logic rst_n,
    coordinate_centroid_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SNAP, S_DIV, S_LATCH} state_t;
    localparam int BIT_W = $clog2(SUM_W + 1);
    localparam logic [COOR_W-1:0] COL_MAX = COOR_W'(H_ACT - 1);
    localparam logic [COOR_W-1:0] ROW_MAX = COOR_W'(V_ACT - 1);

    state_t            r_state;
    logic              r_vsync, r_de;
    logic [COOR_W-1:0] r_col, r_row;
    logic [CNT_W-1:0]  r_cnt, r_snap_cnt;
    logic [SUM_W-1:0]  r_xsum, r_ysum;
    logic [SUM_W-1:0]  r_xq, r_yq;       // dividend shifts out the top, quotient shifts in
    logic [CNT_W-1:0]  r_xrem, r_yrem;
    logic [BIT_W-1:0]  r_bit;
    logic [COOR_W-1:0] r_x_coor, r_y_coor;
    logic [CNT_W-1:0]  r_pix_cnt;
    logic              r_valid, r_done, r_busy;

    logic              w_frame_start, w_frame_end, w_line_end, w_hit;
    logic [SUM_W:0]    w_xsum_nx, w_ysum_nx;
    logic [CNT_W:0]    w_xtrial, w_ytrial, w_xsub, w_ysub;
    logic              w_xge, w_yge;

    assign w_frame_start = r_vsync & ~bus.vsync_i;
    assign w_frame_end   = ~r_vsync & bus.vsync_i;
    assign w_line_end    = r_de & ~bus.data_en_i;
    assign w_hit         = bus.data_en_i & bus.data_i;

    assign w_xsum_nx = {1'b0, r_xsum} + {{(SUM_W + 1 - COOR_W){1'b0}}, r_col};
    assign w_ysum_nx = {1'b0, r_ysum} + {{(SUM_W + 1 - COOR_W){1'b0}}, r_row};

    assign w_xtrial = {r_xrem, r_xq[SUM_W-1]};
    assign w_ytrial = {r_yrem, r_yq[SUM_W-1]};
    assign w_xsub   = w_xtrial - {1'b0, r_snap_cnt};
    assign w_ysub   = w_ytrial - {1'b0, r_snap_cnt};
    assign w_xge    = w_xtrial >= {1'b0, r_snap_cnt};
    assign w_yge    = w_ytrial >= {1'b0, r_snap_cnt};

`ifdef COORD_BBOX_EN
    logic [COOR_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [COOR_W-1:0] r_sxmin, r_sxmax, r_symin, r_symax;
    logic [COOR_W-1:0] r_oxmin, r_oxmax, r_oymin, r_oymax;
`endif

    // vsync idles high between frames, so its copy resets high to avoid a false frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_cnt   <= '0;
            r_xsum  <= '0;
            r_ysum  <= '0;
`ifdef COORD_BBOX_EN
            r_xmin  <= '1;
            r_xmax  <= '0;
            r_ymin  <= '1;
            r_ymax  <= '0;
`endif
        end else begin
            r_vsync <= bus.vsync_i;
            r_de    <= bus.data_en_i;
            if (bus.data_en_i) begin
                if (r_col != COL_MAX) r_col <= r_col + 1'b1;
            end else begin
                r_col <= '0;
            end
            if (w_frame_start) begin
                r_row  <= '0;
                r_cnt  <= '0;
                r_xsum <= '0;
                r_ysum <= '0;
`ifdef COORD_BBOX_EN
                r_xmin <= '1;
                r_xmax <= '0;
                r_ymin <= '1;
                r_ymax <= '0;
`endif
            end else begin
                if (w_line_end && r_row != ROW_MAX) r_row <= r_row + 1'b1;
                if (w_hit) begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    r_xsum <= w_xsum_nx[SUM_W] ? '1 : w_xsum_nx[SUM_W-1:0];
                    r_ysum <= w_ysum_nx[SUM_W] ? '1 : w_ysum_nx[SUM_W-1:0];
`ifdef COORD_BBOX_EN
                    if (r_col < r_xmin) r_xmin <= r_col;
                    if (r_col > r_xmax) r_xmax <= r_col;
                    if (r_row < r_ymin) r_ymin <= r_row;
                    if (r_row > r_ymax) r_ymax <= r_row;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_snap_cnt <= '0;
            r_xq       <= '0;
            r_yq       <= '0;
            r_xrem     <= '0;
            r_yrem     <= '0;
            r_bit      <= '0;
            r_x_coor   <= '0;
            r_y_coor   <= '0;
            r_pix_cnt  <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef COORD_BBOX_EN
            {r_sxmin, r_sxmax, r_symin, r_symax} <= '0;
            {r_oxmin, r_oxmax, r_oymin, r_oymax} <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_frame_end) r_state <= S_SNAP;
                S_SNAP: begin
                    r_snap_cnt <= r_cnt;
                    r_xrem     <= '0;
                    r_yrem     <= '0;
                    r_bit      <= '0;
`ifdef COORD_BBOX_EN
                    {r_sxmin, r_sxmax, r_symin, r_symax} <= {r_xmin, r_xmax, r_ymin, r_ymax};
`endif
                    if (r_cnt == '0) begin
                        r_xq    <= '0;
                        r_yq    <= '0;
                        r_state <= S_LATCH;
                    end else begin
                        r_xq    <= r_xsum;
                        r_yq    <= r_ysum;
                        r_busy  <= 1'b1;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_xrem <= w_xge ? w_xsub[CNT_W-1:0] : w_xtrial[CNT_W-1:0];
                    r_yrem <= w_yge ? w_ysub[CNT_W-1:0] : w_ytrial[CNT_W-1:0];
                    r_xq   <= {r_xq[SUM_W-2:0], w_xge};
                    r_yq   <= {r_yq[SUM_W-2:0], w_yge};
                    r_bit  <= r_bit + 1'b1;
                    if (r_bit == BIT_W'(SUM_W - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_x_coor  <= r_xq[COOR_W-1:0];
                    r_y_coor  <= r_yq[COOR_W-1:0];
                    r_pix_cnt <= r_snap_cnt;
                    r_valid   <= r_snap_cnt >= CNT_W'(MIN_PIX);
                    r_done    <= 1'b1;
`ifdef COORD_BBOX_EN
                    if (r_snap_cnt == '0)
                        {r_oxmin, r_oxmax, r_oymin, r_oymax} <= '0;
                    else
                        {r_oxmin, r_oxmax, r_oymin, r_oymax} <= {r_sxmin, r_sxmax, r_symin, r_symax};
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.x_coor          = r_x_coor;
    assign bus.y_coor          = r_y_coor;
    assign bus.pix_cnt         = r_pix_cnt;
    assign bus.coor_valid_flag = r_valid;
    assign bus.frame_done      = r_done;
    assign bus.busy            = r_busy;
    assign bus.o_dbg_state     = r_state;
`ifdef COORD_BBOX_EN
    assign bus.x_min = r_oxmin;
    assign bus.x_max = r_oxmax;
    assign bus.y_min = r_oymin;
    assign bus.y_max = r_oymax;
`endif
endmodule

// File: tb/tb_coordinate_centroid_seq.sv
// Directed-frame bench for coordinate_centroid_seq: a frame-level model predicts each result
// and its timing; two instances differ only in MIN_PIX (1 and 20).
module tb_coordinate_centroid_seq;
    localparam int H_ACT = 16, V_ACT = 8, COOR_W = 4, CNT_W = 8, SUM_W = 11;

    typedef struct {
        int end_c; int done_c; int cnt; int x; int y;
        int xmin; int xmax; int ymin; int ymax;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b1, de = 1'b0, din = 1'b0;
    bit   skip = 1'b0;
    int   cyc = 0;
    int   n_vec = 0, n_fail = 0;
    bit   img [0:V_ACT-1][0:31];
    exp_t exp_q[$];
    exp_t held;
    bit   cmp_done, cmp_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coordinate_centroid_seq_if #(.COOR_W(COOR_W), .CNT_W(CNT_W)) ifa ();
    coordinate_centroid_seq_if #(.COOR_W(COOR_W), .CNT_W(CNT_W)) ifb ();

    assign ifa.vsync_i = vsync; assign ifa.hsync_i = de; assign ifa.data_en_i = de; assign ifa.data_i = din;
    assign ifb.vsync_i = vsync; assign ifb.hsync_i = de; assign ifb.data_en_i = de; assign ifb.data_i = din;

    coordinate_centroid_seq #(.H_ACT(H_ACT), .V_ACT(V_ACT), .COOR_W(COOR_W), .CNT_W(CNT_W),
        .SUM_W(SUM_W), .MIN_PIX(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    coordinate_centroid_seq #(.H_ACT(H_ACT), .V_ACT(V_ACT), .COOR_W(COOR_W), .CNT_W(CNT_W),
        .SUM_W(SUM_W), .MIN_PIX(20)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_img();
        for (int r = 0; r < V_ACT; r++)
            for (int i = 0; i < 32; i++) img[r][i] = 1'b0;
    endtask

    task automatic set_block(input int c0, input int c1, input int r0, input int r1);
        for (int r = r0; r <= r1; r++)
            for (int i = c0; i <= c1; i++) img[r][i] = 1'b1;
    endtask

    // Frame-level prediction: plain counting and floor division over the image just sent.
    task automatic push_exp(input int hlen, input int end_c);
        exp_t e;
        int   n = 0, xs = 0, ys = 0, c;
        e.xmin = 99; e.xmax = 0; e.ymin = 99; e.ymax = 0;
        for (int r = 0; r < V_ACT; r++)
            for (int i = 0; i < hlen; i++)
                if (img[r][i]) begin
                    c = (i > H_ACT - 1) ? H_ACT - 1 : i;
                    n++; xs += c; ys += r;
                    if (c < e.xmin) e.xmin = c;
                    if (c > e.xmax) e.xmax = c;
                    if (r < e.ymin) e.ymin = r;
                    if (r > e.ymax) e.ymax = r;
                end
        e.cnt = n;
        e.x = (n == 0) ? 0 : (xs / n) % (1 << COOR_W);
        e.y = (n == 0) ? 0 : (ys / n) % (1 << COOR_W);
        if (n == 0) begin e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0; end
        e.end_c  = end_c;
        e.done_c = end_c + ((n == 0) ? 2 : SUM_W + 2);
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input int hlen, input bit push, input int tail);
        @(negedge clk); vsync = 1'b0;
        repeat (2) @(negedge clk);
        for (int r = 0; r < V_ACT; r++) begin
            for (int i = 0; i < hlen; i++) begin
                de = 1'b1; din = img[r][i];
                @(negedge clk);
            end
            de = 1'b0; din = 1'b0;
            repeat (3) @(negedge clk);
        end
        vsync = 1'b1;
        if (push) push_exp(hlen, cyc + 1);
        repeat (tail) @(negedge clk);
    endtask

    task automatic lit(input string tag, input int x, input int y, input int p, input int va, input int vb);
        chk({tag, "_x"}, ifa.x_coor, x);
        chk({tag, "_y"}, ifa.y_coor, y);
        chk({tag, "_pix"}, ifa.pix_cnt, p);
        chk({tag, "_valid_a"}, ifa.coor_valid_flag, va);
        chk({tag, "_valid_b"}, ifb.coor_valid_flag, vb);
    endtask

    always @(negedge clk) begin
        if (rst_n && !skip) begin
            cmp_done = (exp_q.size() > 0) && (cyc == exp_q[0].done_c);
            cmp_busy = (exp_q.size() > 0) && (exp_q[0].cnt != 0) &&
                       (cyc >= exp_q[0].end_c + 1) && (cyc <= exp_q[0].end_c + SUM_W);
            chk("frame_done_a", ifa.frame_done, cmp_done);
            chk("frame_done_b", ifb.frame_done, cmp_done);
            chk("busy_a", ifa.busy, cmp_busy);
            chk("busy_b", ifb.busy, cmp_busy);
            if (cmp_done) held = exp_q.pop_front();
            chk("x_coor", ifa.x_coor, held.x);
            chk("y_coor", ifa.y_coor, held.y);
            chk("pix_cnt", ifa.pix_cnt, held.cnt % (1 << CNT_W));
            chk("valid_a", ifa.coor_valid_flag, held.cnt >= 1);
            chk("valid_b", ifb.coor_valid_flag, held.cnt >= 20);
            chk("x_coor_b", ifb.x_coor, held.x);
`ifdef COORD_BBOX_EN
            chk("x_min", ifa.x_min, held.xmin);
            chk("x_max", ifa.x_max, held.xmax);
            chk("y_min", ifa.y_min, held.ymin);
            chk("y_max", ifa.y_max, held.ymax);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        held = '{default: 0};
        repeat (3) @(negedge clk);
        lit("reset", 0, 0, 0, 0, 0);
        chk("reset_busy", ifa.busy, 0);
        chk("reset_done", ifa.frame_done, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single pixel at (5,3)
        clear_img(); img[3][5] = 1'b1;
        run_frame(H_ACT, 1, SUM_W + 6);
        lit("single", 5, 3, 1, 1, 0);

        // 4x4 block: xsum=56, ysum=40, 16 pixels -> floor 3, 2; below MIN_PIX=20 on instance b
        clear_img(); set_block(2, 5, 1, 4);
        run_frame(H_ACT, 1, SUM_W + 6);
        lit("block4", 3, 2, 16, 1, 0);
`ifdef COORD_BBOX_EN
        chk("block4_xmin", ifa.x_min, 2); chk("block4_xmax", ifa.x_max, 5);
        chk("block4_ymin", ifa.y_min, 1); chk("block4_ymax", ifa.y_max, 4);
`endif

        // Empty frame: result after 2 cycles, all zero
        clear_img();
        run_frame(H_ACT, 1, 6);
        lit("empty", 0, 0, 0, 0, 0);

        // 5x5 block at cols 10-14, rows 3-7: xsum=300, ysum=125 -> 12, 5; valid on both
        clear_img(); set_block(10, 14, 3, 7);
        run_frame(H_ACT, 1, SUM_W + 6);
        lit("block5", 12, 5, 25, 1, 1);

        // Corner pixel, then the next frame starts three cycles into the division
        clear_img(); img[7][15] = 1'b1;
        run_frame(H_ACT, 1, 3);
        clear_img(); set_block(2, 5, 1, 4);
        run_frame(H_ACT, 1, SUM_W + 6);
        lit("overlap_b", 3, 2, 16, 1, 0);

        // Overlong lines: pixels past column 15 count as column 15
        clear_img(); img[0][16] = 1'b1; img[0][17] = 1'b1;
        run_frame(H_ACT + 2, 1, SUM_W + 6);
        lit("colsat", 15, 0, 2, 1, 0);

        // Reset pulse while dividing: outputs clear and the aborted frame never reports
        skip = 1'b1;
        clear_img(); img[1][1] = 1'b1;
        run_frame(H_ACT, 0, 0);
        repeat (5) @(negedge clk);
        chk("middiv_busy", ifa.busy, 1);
        rst_n = 1'b0;
        #1;
        lit("rst_mid", 0, 0, 0, 0, 0);
        chk("rst_mid_busy", ifa.busy, 0);
        chk("rst_mid_done", ifa.frame_done, 0);
        @(negedge clk);
        held = '{default: 0};
        rst_n = 1'b1;
        skip = 1'b0;
        repeat (20) @(negedge clk);

        clear_img(); img[6][9] = 1'b1;
        run_frame(H_ACT, 1, SUM_W + 6);
        lit("after_rst", 9, 6, 1, 1, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
